// File: rtl/row_packer_pkg.sv
// Shared widths, defaults and slot addressing for the row packer.
package row_packer_pkg;

  localparam int unsigned PIX_W       = 24;
  localparam int unsigned SLOT_W      = 32;
  localparam int unsigned PAD_W       = SLOT_W - PIX_W;
  localparam int unsigned COL_DEFAULT = 1920;
  localparam int unsigned ROW_DEFAULT = 1080;
  localparam int unsigned IDX_W       = 11;

  // Per-row tag carried alongside a full buffer.
  typedef struct packed {
    logic             first;
    logic [IDX_W-1:0] idx;
  } row_tag_t;

  // Low bit of pixel slot k inside a packed row word.
  function automatic int unsigned slot_lo(input int unsigned k);
    return k * SLOT_W;
  endfunction

endpackage

// File: rtl/row_buf.sv
// One row-wide pixel buffer: per-slot write, full flag and row tag.
module row_buf
  import row_packer_pkg::*;
#(
  parameter int unsigned COL   = COL_DEFAULT,
  parameter int unsigned CNT_W = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_slot,
  input  logic [PIX_W-1:0]      wr_data,
  input  logic                  set_full,
  input  row_tag_t              set_tag,
  input  logic                  clr_full,
  output logic                  full,
  output row_tag_t              tag,
  output logic [COL*SLOT_W-1:0] data
);

  logic [SLOT_W-1:0] slot_q [COL];

  // Pixel storage; pad byte is forced to zero on every write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_q[wr_slot] <= {PAD_W'(0), wr_data};
    end
  end

  // Full flag and tag; set and clear never target the same buffer in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      tag  <= '0;
    end else if (set_full) begin
      full <= 1'b1;
      tag  <= set_tag;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

  // Flatten slots into the packed row word.
  for (genvar k = 0; k < COL; k++) begin : g_pack
    assign data[slot_lo(k) +: SLOT_W] = slot_q[k];
  end

endmodule

// File: rtl/row_packer.sv
// Packs a raster pixel stream into ping-pong row words with frame/row tagging.
module row_packer
  import row_packer_pkg::*;
#(
  parameter int unsigned COL = COL_DEFAULT,
  parameter int unsigned ROW = ROW_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [COL*SLOT_W-1:0] row_out,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic                  row_first,
  output logic [IDX_W-1:0]      row_idx,
  output logic                  sof_err
);

  localparam int unsigned      CNT_W    = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL - 1);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROW - 1);

  logic [CNT_W-1:0] col_cnt, col_nxt, eff_col;
  logic [IDX_W-1:0] row_cnt, row_nxt, eff_row;
  logic             wr_ptr, wr_ptr_nxt;
  logic             rd_ptr, rd_ptr_nxt;
  logic             sof_err_nxt;
  logic             accept, xfer, sof_beat, row_done;
  row_tag_t         done_tag;

  logic [1:0]           buf_wr, buf_set, buf_clr, buf_full;
  row_tag_t             buf_tag  [2];
  logic [COL*SLOT_W-1:0] buf_data [2];

  // Two row buffers alternating between fill and read roles.
  for (genvar b = 0; b < 2; b++) begin : g_buf
    row_buf #(
      .COL   (COL),
      .CNT_W (CNT_W)
    ) u_buf (
      .clk      (CLK),
      .rst      (RST),
      .wr_en    (buf_wr[b]),
      .wr_slot  (eff_col),
      .wr_data  (pix_in),
      .set_full (buf_set[b]),
      .set_tag  (done_tag),
      .clr_full (buf_clr[b]),
      .full     (buf_full[b]),
      .tag      (buf_tag[b]),
      .data     (buf_data[b])
    );
  end

  // Handshake and read-side view of the oldest full buffer.
  assign pix_ready = ~RST & ~buf_full[wr_ptr];
  assign row_valid = buf_full[rd_ptr];
  assign row_out   = row_valid ? buf_data[rd_ptr] : '0;
  assign row_first = row_valid & buf_tag[rd_ptr].first;
  assign row_idx   = row_valid ? buf_tag[rd_ptr].idx : '0;

  // Next-state: pixel accept, row completion, sof restart and row transfer.
  always_comb begin
    col_nxt     = col_cnt;
    row_nxt     = row_cnt;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    buf_wr      = '0;
    buf_set     = '0;
    buf_clr     = '0;

    accept      = pix_valid & pix_ready;
    xfer        = row_valid & row_ready;
    sof_beat    = accept & pix_sof;
    eff_col     = sof_beat ? '0 : col_cnt;
    eff_row     = sof_beat ? '0 : row_cnt;
    row_done    = accept & (eff_col == COL_LAST);
    sof_err_nxt = sof_beat & (col_cnt != '0);

    done_tag.idx   = eff_row;
    done_tag.first = (eff_row == '0);

    if (accept) begin
      buf_wr[wr_ptr] = 1'b1;
      if (row_done) begin
        buf_set[wr_ptr] = 1'b1;
        col_nxt         = '0;
        row_nxt         = (eff_row == ROW_LAST) ? '0 : eff_row + IDX_W'(1);
        wr_ptr_nxt      = ~wr_ptr;
      end else begin
        col_nxt = eff_col + CNT_W'(1);
        row_nxt = eff_row;
      end
    end

    if (xfer) begin
      buf_clr[rd_ptr] = 1'b1;
      rd_ptr_nxt      = ~rd_ptr;
    end
  end

  // Counter, pointer and error-pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_cnt <= '0;
      row_cnt <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      sof_err <= sof_err_nxt;
    end
  end

endmodule
